// File: rtl/if_fetch_stage.sv
// Instruction fetch: PC generation, single-outstanding imem requests,
// and a 2-entry in-order {pc, instr} buffer feeding the IF/ID register.
module if_fetch_stage #(
   parameter int           N        = 32,
   parameter int           A        = 32,
   parameter logic [A-1:0] RESET_PC = '0,
   parameter logic [A-1:0] PC_STEP  = A'(4)
) (
   input  logic         clock,
   input  logic         reset,
   output logic         imem_req,
   output logic [A-1:0] imem_addr,
   input  logic         imem_rvalid,
   input  logic [N-1:0] imem_rdata,
   input  logic         redirect_valid,
   input  logic [A-1:0] redirect_pc,
   input  logic         ready_id,
   output logic         valid_if,
   output logic [N-1:0] instr_if,
   output logic [A-1:0] pc_if
);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      WAIT_STALE
   } state_t;

   typedef struct packed {
      logic [A-1:0] pc;
      logic [N-1:0] instr;
   } entry_t;

   state_t       state_q, state_d;
   logic [A-1:0] pc_q, pc_d;
   logic [A-1:0] fly_q, fly_d;
   logic [1:0]   count_q, count_d;
   logic         rd_ptr_q, wr_ptr_q;
   entry_t       fifo_q [2];
   entry_t       head;
   logic         push, pop, resp, issue;

   always_comb begin
      head     = fifo_q[rd_ptr_q];
      valid_if = (count_q != 2'd0) && !redirect_valid && !reset;
      pop      = valid_if && ready_id;
      push     = (state_q == WAIT) && imem_rvalid && !redirect_valid;
      resp     = imem_rvalid && (state_q != IDLE);
      count_d  = count_q + {1'b0, push} - {1'b0, pop};
      issue    = !reset && !redirect_valid && (count_d < 2'd2)
               && ((state_q == IDLE) || resp);
      instr_if = valid_if ? head.instr : '0;
      pc_if    = valid_if ? head.pc : '0;
   end

   // Redirect outranks everything; a request still in flight at redirect
   // time leaves us in WAIT_STALE so its response is swallowed.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      fly_d     = fly_q;
      imem_req  = 1'b0;
      imem_addr = '0;
      unique case (1'b1)
         redirect_valid: begin
            pc_d = redirect_pc;
            if (state_q == WAIT && !imem_rvalid)
               state_d = WAIT_STALE;
            else if (resp)
               state_d = IDLE;
         end
         issue: begin
            imem_req  = 1'b1;
            imem_addr = pc_q;
            fly_d     = pc_q;
            pc_d      = pc_q + PC_STEP;
            state_d   = WAIT;
         end
         (resp && !issue && !redirect_valid): begin
            state_d = IDLE;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= IDLE;
         pc_q     <= RESET_PC;
         fly_q    <= '0;
         count_q  <= '0;
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         fly_q   <= fly_d;
         if (redirect_valid) begin
            count_q  <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
         end else begin
            count_q <= count_d;
            if (push)
               wr_ptr_q <= ~wr_ptr_q;
            if (pop)
               rd_ptr_q <= ~rd_ptr_q;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (push && !reset)
         fifo_q[wr_ptr_q] <= '{pc: fly_q, instr: imem_rdata};
   end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: latency-configurable imem model, delivered
// stream replayed against an in-order PC sequence model.
module tb_if_fetch_stage;
   localparam int N = 32;
   localparam int A = 32;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic         reset, redirect_valid, ready_id;
   logic [A-1:0] redirect_pc;
   logic         imem_req, valid_if;
   logic [A-1:0] imem_addr, pc_if;
   logic [N-1:0] instr_if;
   logic         imem_rvalid = 1'b0;
   logic [N-1:0] imem_rdata = '0;

   logic         w_reset, w_rvalid, w_redirect, w_ready;
   logic [A-1:0] w_redirect_pc;
   logic [N-1:0] w_rdata;
   logic         w_req, w_valid;
   logic [A-1:0] w_addr, w_pc;
   logic [N-1:0] w_instr;

   if_fetch_stage #(
      .N(N), .A(A), .RESET_PC(32'h0), .PC_STEP(32'd4)
   ) dut (
      .clock(clock), .reset(reset),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .ready_id(ready_id), .valid_if(valid_if),
      .instr_if(instr_if), .pc_if(pc_if)
   );

   if_fetch_stage #(
      .N(N), .A(A), .RESET_PC(32'hFFFF_FFFC), .PC_STEP(32'd4)
   ) dut_w (
      .clock(clock), .reset(w_reset),
      .imem_req(w_req), .imem_addr(w_addr),
      .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
      .redirect_valid(w_redirect), .redirect_pc(w_redirect_pc),
      .ready_id(w_ready), .valid_if(w_valid),
      .instr_if(w_instr), .pc_if(w_pc)
   );

   typedef struct {
      int           due;
      logic [A-1:0] addr;
      int           ep;
   } req_t;

   // kind: 0 reset, 1 redirect, 2 handshake
   typedef struct {
      int           kind;
      logic [A-1:0] pc;
      logic [N-1:0] instr;
   } ev_t;

   req_t pend[$];
   ev_t  ev[$];
   req_t r_tmp;
   ev_t  e_tmp;
   int   cyc = 0;
   int   epoch = 0;
   int   out_viol = 0;
   int   stall_viol = 0;
   int   lat = 1;
   bit   lat_rand = 1'b0;
   bit   force_rv = 1'b0;
   bit   hold_prev = 1'b0;
   logic [A-1:0] prev_pc = '0;
   logic [N-1:0] prev_instr = '0;

   int n_cmp = 0;
   int n_fail = 0;

   // Memory answers each request with 0x1000_0000+addr after its latency;
   // the same process monitors handshakes and protocol invariants.
   always begin
      @(posedge clock);
      cyc++;
      #2;
      imem_rvalid = force_rv;
      imem_rdata  = force_rv ? 32'hDEAD_BEEF : '0;
      for (int i = 0; i < pend.size(); i++) begin
         if (pend[i].due == cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'h1000_0000 + pend[i].addr;
            pend.delete(i);
            break;
         end
      end
      @(negedge clock);
      if (reset) begin
         epoch++;
         hold_prev   = 1'b0;
         e_tmp.kind  = 0;
         e_tmp.pc    = '0;
         e_tmp.instr = '0;
         ev.push_back(e_tmp);
      end else begin
         if (redirect_valid) begin
            e_tmp.kind  = 1;
            e_tmp.pc    = redirect_pc;
            e_tmp.instr = '0;
            ev.push_back(e_tmp);
         end else if (valid_if && ready_id) begin
            e_tmp.kind  = 2;
            e_tmp.pc    = pc_if;
            e_tmp.instr = instr_if;
            ev.push_back(e_tmp);
         end
         if (hold_prev && valid_if &&
             (pc_if !== prev_pc || instr_if !== prev_instr))
            stall_viol++;
         hold_prev  = valid_if && !ready_id;
         prev_pc    = pc_if;
         prev_instr = instr_if;
         if (imem_req) begin
            foreach (pend[i])
               if (pend[i].ep == epoch) out_viol++;
            r_tmp.due  = cyc + (lat_rand ? int'($urandom_range(4, 1)) : lat);
            r_tmp.addr = imem_addr;
            r_tmp.ep   = epoch;
            pend.push_back(r_tmp);
         end
      end
   end

   task automatic step_cyc();
      @(posedge clock);
      #1;
   endtask

   // Leaves the caller in the first cycle with reset low, before sampling.
   task automatic do_reset();
      int guard;
      step_cyc();
      reset = 1'b1;
      redirect_valid = 1'b0;
      force_rv = 1'b0;
      ready_id = 1'b1;
      repeat (2) step_cyc();
      guard = 0;
      while (pend.size() != 0 && guard < 20) begin
         step_cyc();
         guard++;
      end
      if (pend.size() != 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL reset_drain pending=%0d want 0", pend.size());
      end
      step_cyc();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      lat = 1;
      lat_rand = 1'b0;
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step_cyc();
         @(negedge clock);
         n_cmp++;
         if ({imem_req, valid_if, imem_addr, pc_if, instr_if} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got req=%b v=%b a=%h pc=%h in=%h want all 0",
                     imem_req, valid_if, imem_addr, pc_if, instr_if);
         end
      end
      step_cyc();
      reset = 1'b0;
      @(negedge clock);
      n_cmp++;
      if ({imem_req, imem_addr, valid_if} !== {1'b1, 32'h0, 1'b0}) begin
         n_fail++;
         $display("FAIL first_req got req=%b a=%h v=%b want req=1 a=0 v=0",
                  imem_req, imem_addr, valid_if);
      end
   endtask

   task automatic test_seq_l1();
      logic [A-1:0] wp;
      lat = 1;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         if (i > 0) step_cyc();
         @(negedge clock);
         n_cmp++;
         if ({imem_req, imem_addr} !== {1'b1, 32'(4 * i)}) begin
            n_fail++;
            $display("FAIL l1_req c%0d got req=%b a=%h want req=1 a=%h",
                     i, imem_req, imem_addr, 32'(4 * i));
         end
         wp = (i >= 2) ? 32'(4 * (i - 2)) : '0;
         n_cmp++;
         if ({valid_if, pc_if, instr_if} !==
             {i >= 2, wp, (i >= 2) ? 32'h1000_0000 + wp : 32'h0}) begin
            n_fail++;
            $display("FAIL l1_out c%0d got v=%b pc=%h in=%h want v=%b pc=%h",
                     i, valid_if, pc_if, instr_if, i >= 2, wp);
         end
      end
   endtask

   task automatic test_lat3();
      bit           wreq, wv;
      logic [A-1:0] wa, wp;
      lat = 3;
      do_reset();
      for (int i = 0; i < 13; i++) begin
         if (i > 0) step_cyc();
         @(negedge clock);
         wreq = (i % 3 == 0);
         wa   = wreq ? 32'(4 * (i / 3)) : '0;
         wv   = (i >= 4) && ((i - 4) % 3 == 0);
         wp   = wv ? 32'(4 * ((i - 4) / 3)) : '0;
         n_cmp++;
         if ({imem_req, imem_addr, valid_if, pc_if} !== {wreq, wa, wv, wp}) begin
            n_fail++;
            $display("FAIL l3 c%0d got req=%b a=%h v=%b pc=%h want req=%b a=%h v=%b pc=%h",
                     i, imem_req, imem_addr, valid_if, pc_if, wreq, wa, wv, wp);
         end
      end
   endtask

   task automatic test_stall();
      int           base, npop;
      logic [A-1:0] exp_pc;
      lat = 1;
      do_reset();
      base = ev.size();
      for (int i = 0; i < 18; i++) begin
         if (i > 0) step_cyc();
         ready_id = !(i >= 3 && i <= 8);
         @(negedge clock);
         if (i >= 3 && i <= 8) begin
            n_cmp++;
            if ({valid_if, pc_if, instr_if, imem_req} !==
                {1'b1, 32'h4, 32'h1000_0004, 1'b0}) begin
               n_fail++;
               $display("FAIL stall_hold c%0d got v=%b pc=%h in=%h req=%b want v=1 pc=4 req=0",
                        i, valid_if, pc_if, instr_if, imem_req);
            end
         end
         if (i == 9) begin
            n_cmp++;
            if ({imem_req, imem_addr} !== {1'b1, 32'hC}) begin
               n_fail++;
               $display("FAIL stall_resume got req=%b a=%h want req=1 a=c",
                        imem_req, imem_addr);
            end
         end
      end
      exp_pc = '0;
      npop = 0;
      for (int j = base; j < ev.size(); j++) begin
         if (ev[j].kind == 2) begin
            n_cmp++;
            if (ev[j].pc !== exp_pc || ev[j].instr !== 32'h1000_0000 + exp_pc) begin
               n_fail++;
               $display("FAIL stall_stream got pc=%h in=%h want pc=%h",
                        ev[j].pc, ev[j].instr, exp_pc);
            end
            exp_pc += 4;
            npop++;
         end
      end
      n_cmp++;
      if (npop < 8) begin
         n_fail++;
         $display("FAIL stall_count got %0d want >=8", npop);
      end
   endtask

   task automatic test_redirect_wait();
      lat = 4;
      do_reset();
      ready_id = 1'b0;
      for (int i = 0; i < 14; i++) begin
         if (i > 0) step_cyc();
         redirect_valid = (i == 6);
         redirect_pc    = 32'h200;
         ready_id       = (i >= 7);
         @(negedge clock);
         if (i == 5 || i == 13) begin
            n_cmp++;
            if ({valid_if, pc_if, instr_if} !==
                ((i == 5) ? {1'b1, 32'h0, 32'h1000_0000}
                          : {1'b1, 32'h200, 32'h1000_0200})) begin
               n_fail++;
               $display("FAIL rdw_head c%0d got v=%b pc=%h in=%h",
                        i, valid_if, pc_if, instr_if);
            end
         end else if (i >= 6) begin
            n_cmp++;
            if ({valid_if, imem_req, imem_addr} !==
                {1'b0, i == 8 || i == 12,
                 (i == 8) ? 32'h200 : (i == 12) ? 32'h204 : 32'h0}) begin
               n_fail++;
               $display("FAIL rdw c%0d got v=%b req=%b a=%h",
                        i, valid_if, imem_req, imem_addr);
            end
         end
      end
      redirect_valid = 1'b0;
   endtask

   task automatic test_redirect_rvalid();
      lat = 1;
      do_reset();
      ready_id = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (i > 0) step_cyc();
         redirect_valid = (i == 3) || (i == 12);
         redirect_pc    = (i == 3) ? 32'h300 : 32'h440;
         force_rv       = (i == 3);
         ready_id       = (i >= 4);
         @(negedge clock);
         case (i)
            2: begin
               n_cmp++;
               if ({valid_if, pc_if, imem_req} !== {1'b1, 32'h0, 1'b0}) begin
                  n_fail++;
                  $display("FAIL rdr_full got v=%b pc=%h req=%b want v=1 pc=0 req=0",
                           valid_if, pc_if, imem_req);
               end
            end
            3, 12: begin
               n_cmp++;
               if ({valid_if, imem_req} !== 2'b00) begin
                  n_fail++;
                  $display("FAIL rdr_cycle c%0d got v=%b req=%b want 0 0",
                           i, valid_if, imem_req);
               end
            end
            4, 13: begin
               n_cmp++;
               if ({valid_if, imem_req, imem_addr} !==
                   {1'b0, 1'b1, (i == 4) ? 32'h300 : 32'h440}) begin
                  n_fail++;
                  $display("FAIL rdr_next c%0d got v=%b req=%b a=%h",
                           i, valid_if, imem_req, imem_addr);
               end
            end
            5, 14: begin
               n_cmp++;
               if (valid_if !== 1'b0) begin
                  n_fail++;
                  $display("FAIL rdr_drop c%0d got v=%b want 0", i, valid_if);
               end
            end
            6, 15: begin
               n_cmp++;
               if ({valid_if, pc_if, instr_if} !==
                   ((i == 6) ? {1'b1, 32'h300, 32'h1000_0300}
                             : {1'b1, 32'h440, 32'h1000_0440})) begin
                  n_fail++;
                  $display("FAIL rdr_head c%0d got v=%b pc=%h in=%h",
                           i, valid_if, pc_if, instr_if);
               end
            end
            default: begin
            end
         endcase
      end
      redirect_valid = 1'b0;
      force_rv = 1'b0;
   endtask

   task automatic test_random();
      int           base, npop;
      logic [A-1:0] exp_pc;
      lat_rand = 1'b1;
      do_reset();
      base = ev.size();
      for (int i = 0; i < 500; i++) begin
         if (i > 0) step_cyc();
         ready_id       = ($urandom_range(3, 0) != 0);
         redirect_valid = ($urandom_range(15, 0) == 0);
         redirect_pc    = 32'($urandom_range(16383, 0)) << 2;
      end
      step_cyc();
      redirect_valid = 1'b0;
      ready_id = 1'b1;
      repeat (12) step_cyc();
      exp_pc = '0;
      npop = 0;
      for (int j = base; j < ev.size(); j++) begin
         if (ev[j].kind == 1) begin
            exp_pc = ev[j].pc;
         end else if (ev[j].kind == 2) begin
            n_cmp++;
            if (ev[j].pc !== exp_pc || ev[j].instr !== 32'h1000_0000 + exp_pc) begin
               n_fail++;
               $display("FAIL rand_stream got pc=%h in=%h want pc=%h",
                        ev[j].pc, ev[j].instr, exp_pc);
            end
            exp_pc += 4;
            npop++;
         end
      end
      n_cmp++;
      if (npop < 50) begin
         n_fail++;
         $display("FAIL rand_progress got %0d want >=50", npop);
      end
      n_cmp++;
      if (out_viol != 0) begin
         n_fail++;
         $display("FAIL one_outstanding got %0d violations want 0", out_viol);
      end
      n_cmp++;
      if (stall_viol != 0) begin
         n_fail++;
         $display("FAIL stall_stable got %0d violations want 0", stall_viol);
      end
      lat_rand = 1'b0;
   endtask

   task automatic test_wrap();
      w_reset = 1'b1;
      repeat (2) step_cyc();
      step_cyc();
      w_reset = 1'b0;
      @(negedge clock);
      n_cmp++;
      if ({w_req, w_addr, w_valid} !== {1'b1, 32'hFFFF_FFFC, 1'b0}) begin
         n_fail++;
         $display("FAIL wrap_c0 got req=%b a=%h v=%b", w_req, w_addr, w_valid);
      end
      step_cyc();
      w_rvalid = 1'b1;
      w_rdata  = 32'hA5A5_0001;
      @(negedge clock);
      n_cmp++;
      if ({w_req, w_addr} !== {1'b1, 32'h0}) begin
         n_fail++;
         $display("FAIL wrap_c1 got req=%b a=%h want req=1 a=0", w_req, w_addr);
      end
      step_cyc();
      w_rdata = 32'hA5A5_0002;
      @(negedge clock);
      n_cmp++;
      if ({w_valid, w_pc, w_instr, w_req, w_addr} !==
          {1'b1, 32'hFFFF_FFFC, 32'hA5A5_0001, 1'b1, 32'h4}) begin
         n_fail++;
         $display("FAIL wrap_c2 got v=%b pc=%h in=%h req=%b a=%h",
                  w_valid, w_pc, w_instr, w_req, w_addr);
      end
      step_cyc();
      w_rvalid = 1'b0;
      w_reset  = 1'b1;
      @(negedge clock);
      n_cmp++;
      if ({w_req, w_addr, w_valid, w_pc, w_instr} !== '0) begin
         n_fail++;
         $display("FAIL wrap_rst got req=%b a=%h v=%b pc=%h in=%h want all 0",
                  w_req, w_addr, w_valid, w_pc, w_instr);
      end
      step_cyc();
      w_reset  = 1'b0;
      w_rvalid = 1'b1;
      w_rdata  = 32'hBAD0_0004;
      @(negedge clock);
      n_cmp++;
      if ({w_valid, w_req, w_addr} !== {1'b0, 1'b1, 32'hFFFF_FFFC}) begin
         n_fail++;
         $display("FAIL wrap_restart got v=%b req=%b a=%h",
                  w_valid, w_req, w_addr);
      end
      step_cyc();
      w_rdata = 32'hA5A5_0003;
      @(negedge clock);
      n_cmp++;
      if (w_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL wrap_late got v=%b pc=%h want v=0", w_valid, w_pc);
      end
      step_cyc();
      w_rvalid = 1'b0;
      @(negedge clock);
      n_cmp++;
      if ({w_valid, w_pc, w_instr} !== {1'b1, 32'hFFFF_FFFC, 32'hA5A5_0003}) begin
         n_fail++;
         $display("FAIL wrap_head got v=%b pc=%h in=%h", w_valid, w_pc, w_instr);
      end
   endtask

   initial begin
      reset          = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      ready_id       = 1'b1;
      w_reset        = 1'b1;
      w_rvalid       = 1'b0;
      w_rdata        = '0;
      w_redirect     = 1'b0;
      w_redirect_pc  = '0;
      w_ready        = 1'b1;
      test_reset();
      test_seq_l1();
      test_lat3();
      test_stall();
      test_redirect_wait();
      test_redirect_rvalid();
      test_random();
      test_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

endmodule
